// File: rtl/lab6_io_pkg.sv
// Shared definitions for the lab 6 input-conditioning logic.
//   DEFAULT_DEBOUNCE_CYCLES : debounce window in clock cycles (10 ms at 50 MHz)
//   KEY_RELEASED            : raw/synchronized level of a released DE2 push-button
package lab6_io_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd500000;
  localparam logic        KEY_RELEASED            = 1'b1;

endpackage : lab6_io_pkg

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchronizer, stable-count filter and
// registered level / press / release outputs.
//   clk_i      : system clock, rising edge
//   rst_ni     : synchronous active-low reset
//   key_raw_i  : asynchronous raw button, active-low
//   level_o    : debounced state, active-high (1 = pressed)
//   press_o    : one-cycle pulse on debounced released -> pressed
//   release_o  : one-cycle pulse on debounced pressed -> released
module debounce_channel
  import lab6_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Stable-count filter: a mismatch must persist DEBOUNCE_CYCLES edges to be
  // accepted; any return to the stable value restarts the count from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output stage: level_q still holds the previous debounced state, so a
  // difference against the current stable value marks the transition edge.
  always_comb begin
    level_d   = ~stable_q;
    press_d   = ~stable_q & ~level_q;
    release_d = stable_q & level_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= KEY_RELEASED;
      s2_q      <= KEY_RELEASED;
      stable_q  <= KEY_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= key_raw_i;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : debounce_channel

// File: rtl/key_debouncer.sv
// Input conditioning for the active-low DE2 push-buttons feeding slc3.
// Each channel is synchronized, debounced and turned into an active-high
// level plus one-cycle press and release pulses.
//   Clk         : 50 MHz system clock
//   Reset       : synchronous, active-low
//   KEY_raw     : asynchronous raw buttons, active-low (0 = pressed)
//   Key_level   : debounced state, active-high
//   Key_press   : one-cycle pulse on released -> pressed
//   Key_release : one-cycle pulse on pressed -> released
module key_debouncer
  import lab6_io_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 32'd3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KEY_raw,
  output logic [NUM_KEYS-1:0] Key_level,
  output logic [NUM_KEYS-1:0] Key_press,
  output logic [NUM_KEYS-1:0] Key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i    (Clk),
      .rst_ni   (Reset),
      .key_raw_i(KEY_raw[i]),
      .level_o  (Key_level[i]),
      .press_o  (Key_press[i]),
      .release_o(Key_release[i])
    );
  end

endmodule : key_debouncer

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
Input-conditioning stage for the active-low DE2 push-buttons (Run, Continue, and similar). It sits directly upstream of the slc3 top level, in place of the bare per-signal synchronizers. Each channel is synchronized with two flops, then debounced with a stable-count filter. Each channel produces a clean active-high level, a one-cycle press pulse and a one-cycle release pulse for the processor's control FSM.

Parameters:
NUM_KEYS, 3, number of independent button channels.
DEBOUNCE_CYCLES, 500000, consecutive cycles a new synchronized value must persist before it is accepted (10 ms at 50 MHz). Must be >= 1.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
Clk  input  1  system clock, 50 MHz; all state updates on the rising edge.
Reset  input  1  synchronous, active-low reset.
KEY_raw  input  NUM_KEYS  asynchronous raw buttons, active-low (0 = pressed).
Key_level  output  NUM_KEYS  debounced state, active-high (1 = pressed).
Key_press  output  NUM_KEYS  one-cycle pulse when the debounced state goes released to pressed.
Key_release  output  NUM_KEYS  one-cycle pulse when the debounced state goes pressed to released.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is sampled only on the Clk rising edge; Reset==0 at an edge applies reset.
- Reset values, per channel:
  - Sync flops s1 and s2 = 1 (released).
  - Internal stable value = 1 (released).
  - Counter = 0.
  - Key_level = 0, Key_press = 0, Key_release = 0.
- Synchronizer: s1 <= KEY_raw[i]; s2 <= s1. No logic between s1 and s2.
- Filter, evaluated each edge when not in reset:
  - If s2 == stable: counter <= 0.
  - If s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2 and counter <= 0.
- Outputs (all registered):
  - Key_level = ~stable.
  - Key_press is high for exactly the one cycle after the edge where stable goes 1->0.
  - Key_release is high for exactly the one cycle after the edge where stable goes 0->1.
  - Key_press and Key_release are never high together on one channel.
- Latency:
  - Raw change settles before edge 0; s2 reflects it after edge 2.
  - Key_level and the pulse change at edge 2+DEBOUNCE_CYCLES.
- Glitch rejection: any return of s2 to stable before the count completes clears the counter. The next mismatch restarts the count from 0.
- DEBOUNCE_CYCLES=1: stable follows s2 one edge after the mismatch; pulses still fire.
- Key held through reset: after reset deasserts, the press is detected as a normal transition. Key_press fires at edge 2+DEBOUNCE_CYCLES counted from the first non-reset edge.
- Reset mid-count: the count is discarded and no pulse is emitted.
- Channels are fully independent; simultaneous activity on several channels produces simultaneous, independent pulses.

Decomposition:
- Shared package lab6_io_pkg:
  - DEFAULT_DEBOUNCE_CYCLES = 500000.
  - KEY_RELEASED = 1'b1.
- Sub-module debounce_channel:
  - One bit: sync flops, counter, stable value, pulse regs.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated NUM_KEYS times via a generate loop in key_debouncer.

Test Plan (DEBOUNCE_CYCLES=4, NUM_KEYS=3):
- Reset low 2 cycles with KEY_raw=3'b111, then release -> all outputs 0; Key_level stays 3'b000 for 20 cycles.
- KEY_raw[0] 1->0 before edge 0, held -> Key_level[0]=1 and Key_press[0]=1 at edge 6. Key_press[0]=0 at edge 7. No Key_release.
- KEY_raw[1] low for 3 cycles, then high -> Key_level[1] stays 0; no pulses on any channel.
- Bouncing KEY_raw[0] 0,1,0,1,0 (1 cycle each), then held 0 -> exactly one Key_press[0], 6 edges after the final 0. Later release held -> exactly one Key_release[0], 6 edges after release.
- KEY_raw[0] and KEY_raw[2] pressed on the same cycle -> Key_press=3'b101 for one cycle at edge 6.
- KEY_raw[2] pressed; Reset pulsed low at edge 4 (mid-count) with the key still held -> no pulse before reset. After reset deasserts, Key_press[2] fires 6 edges later.
